// File: rtl/func_eval_if.sv
// func_eval_if: start/busy handshake between func_eval and the cube-root unit.
//   cr_start_o  start request towards the cube-root unit
//   cr_x_o      cube-root operand
//   cr_busy_i   cube-root unit busy
//   cr_y_i      cube-root result, valid once cr_busy_i falls
// master: the evaluator (func_eval); slave: the cube-root unit.
interface func_eval_if;
  logic       cr_start_o;
  logic [7:0] cr_x_o;
  logic       cr_busy_i;
  logic [7:0] cr_y_i;

  modport master (
    output cr_start_o,
    output cr_x_o,
    input  cr_busy_i,
    input  cr_y_i
  );

  modport slave (
    input  cr_start_o,
    input  cr_x_o,
    output cr_busy_i,
    output cr_y_i
  );
endinterface

// File: rtl/func_eval.sv
// func_eval: evaluates y = a*a + cbrt(b).
// a*a comes from an iterative shift-add squarer that runs while the external
// cube-root unit works on b. Both results are combined by the same adder.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   start          request, sampled only while idle
//   a_in, b_in     8-bit unsigned operands
//   y_out          16-bit result, held until the next result
//   busy_o         high from accept until the result is written
//   done_o         one-cycle pulse with each result write
//   err_o          sticky timeout flag (constant 0 unless the timeout is built)
//   cr             master side of the cube-root handshake (func_eval_if)
// Optional feature: define FUNC_EVAL_TIMEOUT_EN to build a cube-root watchdog
// that aborts after TIMEOUT_CYCLES with y_out = 16'hFFFF and err_o = 1.
module func_eval #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    a_in,
  input  logic [7:0]    b_in,
  output logic [15:0]   y_out,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  func_eval_if.master   cr
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SQUARE  = 2'd1,
    WAIT_CR = 2'd2,
    SUM     = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    a_q;
  logic [2:0]    i_q;
  logic [DW-1:0] acc_q;
  logic [7:0]    root_q;
  logic          cr_seen_q;
  logic          cr_done_q;
  logic [DW-1:0] y_q;
  logic          busy_q;
  logic          done_q;
  logic          cr_start_q;
  logic [7:0]    cr_x_q;

  logic          track_c;
  logic          seen_set_c;
  logic          done_set_c;
  logic [DW-1:0] add_b_c;
  logic [DW-1:0] add_sum_c;

  // Handshake tracker is live in SQUARE and WAIT_CR regardless of the squarer.
  assign track_c    = (state_q == SQUARE) || (state_q == WAIT_CR);
  assign seen_set_c = track_c && cr_start_q && cr.cr_busy_i;
  assign done_set_c = track_c && cr_seen_q && !cr_done_q && !cr.cr_busy_i;

  // Single shared adder: partial product in SQUARE, root in SUM; carry dropped.
  always_comb begin
    add_b_c = DW'(a_q) << i_q;
    if (state_q == SUM) begin
      add_b_c = {8'd0, root_q};
    end
    add_sum_c = acc_q + add_b_c;
  end

`ifdef FUNC_EVAL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout_c;

  // A cube-root completion on the same edge takes priority over the timeout.
  assign timeout_c = track_c && !cr_done_q && !done_set_c &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign err_o     = err_q;
`else
  assign err_o = 1'b0;
  logic unused_timeout_c;
  assign unused_timeout_c = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  // Control FSM, datapath registers and handshake tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_q        <= 8'd0;
      i_q        <= 3'd0;
      acc_q      <= '0;
      root_q     <= 8'd0;
      cr_seen_q  <= 1'b0;
      cr_done_q  <= 1'b0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cr_start_q <= 1'b0;
      cr_x_q     <= 8'd0;
`ifdef FUNC_EVAL_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      if (seen_set_c) begin
        cr_start_q <= 1'b0;
        cr_seen_q  <= 1'b1;
      end
      if (done_set_c) begin
        root_q    <= cr.cr_y_i;
        cr_done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start && !cr.cr_busy_i) begin
            a_q        <= a_in;
            cr_x_q     <= b_in;
            cr_start_q <= 1'b1;
            acc_q      <= '0;
            i_q        <= 3'd0;
            busy_q     <= 1'b1;
            cr_seen_q  <= 1'b0;
            cr_done_q  <= 1'b0;
            state_q    <= SQUARE;
`ifdef FUNC_EVAL_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        SQUARE: begin
          if (a_q[i_q]) begin
            acc_q <= add_sum_c;
          end
          i_q <= i_q + 3'd1;
          if (i_q == 3'd7) begin
            state_q <= WAIT_CR;
          end
        end
        WAIT_CR: begin
          if (cr_done_q) begin
            state_q <= SUM;
          end
        end
        SUM: begin
          y_q     <= add_sum_c;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef FUNC_EVAL_TIMEOUT_EN
      // Watchdog overrides the FSM step above when it fires.
      if (timeout_c) begin
        err_q      <= 1'b1;
        y_q        <= 16'hFFFF;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        cr_start_q <= 1'b0;
        state_q    <= IDLE;
      end else if (track_c && !cr_done_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  assign y_out         = y_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cr.cr_start_o = cr_start_q;
  assign cr.cr_x_o     = cr_x_q;

endmodule
